// File: rtl/siggen_pkg.sv
// Shared types and default widths for the signal generator blocks.
// The delay-line controller imports its state type and width defaults from here.
package siggen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } dl_state_t;

    localparam int DL_ADDRESS_WIDTH = 9;
    localparam int DL_DATA_WIDTH    = 8;

endpackage

// File: rtl/delay_line_ctrl.sv
// Circular delay-line sequencer for an external dual-port sample RAM: one write
// and one delayed read per accepted sample, with output muting while history refills.
module delay_line_ctrl
    import siggen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DL_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DL_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    output logic                     ram_wr_en,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    dout
);

    dl_state_t                state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_reg, fill_cnt_next;
    logic [ADDRESS_WIDTH-1:0] delay_q_reg, delay_q_next;

    logic [ADDRESS_WIDTH-1:0] delay_eff;
    dl_state_t                eff_state;
    logic [ADDRESS_WIDTH-1:0] eff_cnt;
    logic [ADDRESS_WIDTH-1:0] eff_dq;
    logic                     accept;
    logic                     mute;
    logic [ADDRESS_WIDTH-1:0] rd_addr_next;

    logic                     ram_wr_en_reg;
    logic [ADDRESS_WIDTH-1:0] ram_wr_addr_reg, ram_rd_addr_reg;
    logic [DATA_WIDTH-1:0]    ram_din_reg;
    logic                     mute1_reg;
    logic                     valid2_reg, mute2_reg;
    logic                     out_valid_reg;
    logic [DATA_WIDTH-1:0]    dout_reg;

    // A zero delay would make read and write hit the same address; run it as 1.
    assign delay_eff = (delay == '0) ? ADDRESS_WIDTH'(1) : delay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
            delay_q_reg  <= ADDRESS_WIDTH'(1);
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            fill_cnt_reg <= fill_cnt_next;
            delay_q_reg  <= delay_q_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        fill_cnt_next = fill_cnt_reg;
        delay_q_next  = delay_q_reg;
        eff_state     = state_reg;
        eff_cnt       = fill_cnt_reg;
        eff_dq        = delay_q_reg;
        accept        = 1'b0;
        mute          = 1'b0;
        rd_addr_next  = '0;

        unique case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next    = FILL;
                    fill_cnt_next = '0;
                    delay_q_next  = delay_eff;
                end
            end
            FILL, RUN: begin
                if (!en) begin
                    state_next = IDLE;
                end else begin
                    // A new delay restarts the refill; a sample arriving in the
                    // same cycle already belongs to the new delay.
                    if (delay_eff != delay_q_reg) begin
                        eff_state = FILL;
                        eff_cnt   = '0;
                        eff_dq    = delay_eff;
                    end
                    state_next    = eff_state;
                    fill_cnt_next = eff_cnt;
                    delay_q_next  = eff_dq;
                    if (in_valid) begin
                        accept       = 1'b1;
                        mute         = (eff_state == FILL) && (eff_cnt < eff_dq);
                        rd_addr_next = wr_ptr_reg - eff_dq;
                        wr_ptr_next  = wr_ptr_reg + ADDRESS_WIDTH'(1);
                        if (eff_cnt != '1) begin
                            fill_cnt_next = eff_cnt + ADDRESS_WIDTH'(1);
                        end
                        if ((eff_state == FILL) && (eff_cnt == eff_dq - ADDRESS_WIDTH'(1))) begin
                            state_next = RUN;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage 1: RAM access registers, with the mute flag travelling alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_en_reg   <= 1'b0;
            ram_wr_addr_reg <= '0;
            ram_rd_addr_reg <= '0;
            ram_din_reg     <= '0;
            mute1_reg       <= 1'b0;
        end else begin
            ram_wr_en_reg <= accept;
            if (accept) begin
                ram_wr_addr_reg <= wr_ptr_reg;
                ram_rd_addr_reg <= rd_addr_next;
                ram_din_reg     <= din;
                mute1_reg       <= mute;
            end
        end
    end

    // Stages 2 and 3: wait out the RAM read, then register the muted output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid2_reg    <= 1'b0;
            mute2_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
        end else begin
            valid2_reg    <= ram_wr_en_reg;
            mute2_reg     <= mute1_reg;
            out_valid_reg <= valid2_reg;
            dout_reg      <= (valid2_reg && !mute2_reg) ? ram_dout : '0;
        end
    end

    assign ram_wr_en   = ram_wr_en_reg;
    assign ram_rd_en   = ram_wr_en_reg;
    assign ram_wr_addr = ram_wr_addr_reg;
    assign ram_rd_addr = ram_rd_addr_reg;
    assign ram_din     = ram_din_reg;
    assign out_valid   = out_valid_reg;
    assign dout        = dout_reg;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl with a behavioural RAM beside it and a history-based
// reference model: output n is din of accept n-delay, or 0 while history refills.
module tb_delay_line_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] delay = '0;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          out_valid;
    logic [DW-1:0] dout;

    always #5 clk = ~clk;

    delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .din(din),
        .delay(delay), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .out_valid(out_valid), .dout(dout)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            m_active = 0;
    int            m_dq = 1;
    int            m_since = 0;
    int            m_n = 0;
    logic [DW-1:0] m_hist [$];
    exp_t          exp_q [$];
    bit            exp_wr_en;
    logic [AW-1:0] exp_wr_addr, exp_rd_addr;
    logic [DW-1:0] exp_din;
    bit            ev;
    logic [DW-1:0] ed;

    task automatic model_reset();
        m_active = 0;
        m_dq = 1;
        m_since = 0;
        m_n = 0;
        m_hist.delete();
        exp_q.delete();
    endtask

    // Drives one cycle, advances the model, and leaves ev/ed/exp_* describing
    // what should be visible after the edge.
    task automatic step(input logic e, input logic v, input logic [DW-1:0] d, input logic [AW-1:0] dl);
        int   deff;
        bit   mute;
        exp_t x;
        en = e; in_valid = v; din = d; delay = dl;
        deff = (dl == 0) ? 1 : int'(dl);
        exp_wr_en = 0;
        if (!e) begin
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1; m_dq = deff; m_since = 0;
        end else begin
            if (deff != m_dq) begin
                m_dq = deff; m_since = 0;
            end
            if (v) begin
                mute   = m_since < m_dq;
                x.due  = cyc + 3;
                x.data = mute ? '0 : m_hist[m_n - m_dq];
                exp_q.push_back(x);
                exp_wr_en   = 1;
                exp_wr_addr = AW'(m_n);
                exp_rd_addr = AW'(m_n - m_dq);
                exp_din     = d;
                m_hist.push_back(d);
                m_n++;
                m_since++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1; ed = exp_q[0].data; void'(exp_q.pop_front());
        end else begin
            ev = 0; ed = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (ram_wr_en !== 0 || ram_rd_en !== 0 || ram_wr_addr !== 0 || ram_rd_addr !== 0 ||
            ram_din !== 0 || out_valid !== 0 || dout !== 0) begin
            errors++;
            $display("FAIL reset_values wr_en=%0b rd_en=%0b wa=%0d ra=%0d rdin=%0h ov=%0b dout=%0h required all 0",
                     ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_din, out_valid, dout);
        end
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 3'd3);
            checks++;
            if (ram_wr_en !== 0 || out_valid !== 0) begin
                errors++;
                $display("FAIL idle_after_reset wr_en=%0b out_valid=%0b required 0 0", ram_wr_en, out_valid);
            end
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_basic();
        step(1, 0, 8'd0, 3'd4);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 8'(i + 1), 3'd4);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL basic_out cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
            checks++;
            if (ram_wr_en !== exp_wr_en || (exp_wr_en && (ram_rd_en !== 1 || ram_wr_addr !== exp_wr_addr ||
                ram_rd_addr !== exp_rd_addr || ram_din !== exp_din))) begin
                errors++;
                $display("FAIL basic_ram cyc=%0d wr_en=%0b wa=%0d ra=%0d din=%0h required %0b %0d %0d %0h",
                         cyc, ram_wr_en, ram_wr_addr, ram_rd_addr, ram_din, exp_wr_en, exp_wr_addr, exp_rd_addr, exp_din);
            end
        end
        $display("test_basic done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'($urandom), 3'd7);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL wrap_out cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
            checks++;
            if (ram_wr_en !== exp_wr_en || (exp_wr_en && (ram_wr_addr !== exp_wr_addr || ram_rd_addr !== exp_rd_addr))) begin
                errors++;
                $display("FAIL wrap_addr cyc=%0d wr_en=%0b wa=%0d ra=%0d required %0b %0d %0d",
                         cyc, ram_wr_en, ram_wr_addr, ram_rd_addr, exp_wr_en, exp_wr_addr, exp_rd_addr);
            end
        end
        $display("test_wrap done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_delay_change();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'($urandom), (i < 10) ? 3'd4 : 3'd2);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL delay_change cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
        end
        $display("test_delay_change done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_enable_zero();
        for (int i = 0; i < 5; i++) begin
            step(0, 1'(i % 2), 8'($urandom), 3'd0);
            checks++;
            if (ram_wr_en !== 0 || out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL en_low cyc=%0d wr_en=%0b out_valid=%0b dout=%0h required 0 %0b %0h",
                         cyc, ram_wr_en, out_valid, dout, ev, ed);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 8'($urandom), 3'd0);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL en_zero_out cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
            checks++;
            if (ram_wr_en !== exp_wr_en || (exp_wr_en && (ram_wr_addr !== exp_wr_addr || ram_rd_addr !== exp_rd_addr))) begin
                errors++;
                $display("FAIL en_zero_ptr cyc=%0d wr_en=%0b wa=%0d ra=%0d required %0b %0d %0d",
                         cyc, ram_wr_en, ram_wr_addr, ram_rd_addr, exp_wr_en, exp_wr_addr, exp_rd_addr);
            end
        end
        $display("test_enable_zero done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 30; i++) begin
            step(1, (i % 3) == 0, 8'($urandom), 3'd2);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL sparse cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
        end
        $display("test_sparse done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        logic [AW-1:0] dl;
        dl = 3'd3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) dl = AW'($urandom);
            step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 3) != 0), 8'($urandom), dl);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL random cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
        end
        $display("test_random done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h40 + i), 3'd1);
        #2 rst_n = 0;
        #1;
        checks++;
        if (ram_wr_en !== 0 || ram_wr_addr !== 0 || ram_rd_addr !== 0 || ram_din !== 0 ||
            out_valid !== 0 || dout !== 0) begin
            errors++;
            $display("FAIL async_reset wr_en=%0b wa=%0d ra=%0d rdin=%0h ov=%0b dout=%0h required all 0",
                     ram_wr_en, ram_wr_addr, ram_rd_addr, ram_din, out_valid, dout);
        end
        @(negedge clk);
        cyc++;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'($urandom), 3'd1);
            checks++;
            if (ram_wr_en !== 0 || out_valid !== 0) begin
                errors++;
                $display("FAIL post_reset_quiet cyc=%0d wr_en=%0b out_valid=%0b required 0 0", cyc, ram_wr_en, out_valid);
            end
        end
        step(1, 0, 8'd0, 3'd1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 8'($urandom), 3'd1);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed) || (exp_wr_en && ram_wr_addr !== exp_wr_addr)) begin
                errors++;
                $display("FAIL post_reset_run cyc=%0d ov=%0b dout=%0h wa=%0d required %0b %0h %0d",
                         cyc, out_valid, dout, ram_wr_addr, ev, ed, exp_wr_addr);
            end
        end
        $display("test_reset_midstream done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_delay_change();
        test_enable_zero();
        test_sparse();
        test_random();
        test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'd0, 3'd1);
            checks++;
            if (out_valid !== ev || (ev && dout !== ed)) begin
                errors++;
                $display("FAIL drain cyc=%0d out_valid=%0b dout=%0h required %0b %0h", cyc, out_valid, dout, ev, ed);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_left pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencing controller for the signal generator's dual-port sample RAM, turning it into a programmable circular delay line. Each accepted input sample is written at a wrapping write pointer and, in the same RAM access, the sample written `delay` samples earlier is read back. The block sits between the sample source (ROM/counter path) and the output, next to the RAM instance at the top level. It mutes output while history is being refilled after enable or a delay change.

## Interface
- `ADDRESS_WIDTH`, 9, RAM address width; buffer depth 2^ADDRESS_WIDTH.
- `DATA_WIDTH`, 8, sample width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  delay line enabled; low forces IDLE.
- `in_valid`  in  1  one-cycle strobe: `din` holds a new sample.
- `din`  in  DATA_WIDTH  input sample.
- `delay`  in  ADDRESS_WIDTH  delay in samples; 0 treated as 1.
- `ram_wr_en`  out  1  RAM write enable (registered).
- `ram_rd_en`  out  1  RAM read enable (registered, always equal to `ram_wr_en`).
- `ram_wr_addr`  out  ADDRESS_WIDTH  RAM write address (registered).
- `ram_rd_addr`  out  ADDRESS_WIDTH  RAM read address (registered).
- `ram_din`  out  DATA_WIDTH  RAM write data (registered).
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid the cycle after the access edge.
- `out_valid`  out  1  one-cycle strobe: `dout` holds a delayed sample.
- `dout`  out  DATA_WIDTH  delayed sample, 0 when muted.

## Operation
- State machine: IDLE, FILL, RUN.
  - IDLE: no RAM access; `in_valid` ignored. `en`=1 → FILL, with `fill_cnt`=0 and `delay_q` latched from `delay` (0→1).
  - FILL: every accepted sample is written and read. The output is muted while `fill_cnt` < `delay_q`. An accept with `fill_cnt` = `delay_q`−1 → RUN.
  - RUN: every accepted sample is written and read, unmuted.
  - `en`=0 in any state → IDLE next edge. Pointers are held. Samples in flight still complete their output strobe.
- Delay change: in FILL or RUN, `delay` ≠ `delay_q` (after 0→1 mapping) → latch new `delay_q`, `fill_cnt`=0, state FILL.
  - If `in_valid` arrives in that same cycle, it uses the new delay and is sample index 0, muted.
- Accept = `in_valid` && state ∈ {FILL, RUN} && `en`.
- On accept:
  - `ram_wr_addr` = `wr_ptr`.
  - `ram_rd_addr` = (`wr_ptr` − `delay_q`) mod 2^ADDRESS_WIDTH.
  - `ram_din` = `din`.
  - `wr_ptr` increments, wrapping 2^ADDRESS_WIDTH−1 → 0.
- `fill_cnt` is ADDRESS_WIDTH wide and saturates; it is only compared in FILL.
- Mute flag is captured per sample at accept time and pipelined with the access. `dout` = mute ? 0 : `ram_dout`.
- Reset values: `ram_wr_en`/`ram_rd_en`=0, addresses=0, `ram_din`=0, `out_valid`=0, `dout`=0, `wr_ptr`=0, `fill_cnt`=0, `delay_q`=1, state IDLE.
- Reset mid-operation clears the pipeline; no output strobe is produced for samples in flight.

## Timing
- Edge E1 (cycle where `in_valid` is high): RAM-side registers load; `ram_wr_en`=`ram_rd_en`=1 for exactly one cycle.
- E2: RAM performs write and read; `ram_dout` is valid after E2.
- E3: `dout` and `out_valid` register; `out_valid` high for one cycle.
- Latency `in_valid` → `out_valid` is 3 edges. Back-to-back `in_valid` every cycle is supported at full throughput.
- Read and write never collide on an address, since `delay_q` ≥ 1.
- Output equals `din` of the sample accepted exactly `delay_q` accepts earlier.

## Structure
- Shared package `siggen_pkg`:
  - `dl_state_t` enum {IDLE, FILL, RUN}.
  - Default width constants.
- No sub-module: a pointer/FSM block plus a 2-stage valid/mute pipeline.
- The RAM is instantiated beside this block at the top level, not inside it.

## Test plan
- Reset: hold `rst_n`=0 mid-stream → all outputs 0 immediately (asynchronous); after release, state IDLE and no `ram_wr_en` until `en`=1.
- Basic delay: `delay`=4, `en`=1, `din`=1,2,3,… every cycle → `out_valid` from the 3rd edge; `dout`=0,0,0,0,1,2,3,…
- Wrap: ADDRESS_WIDTH=3, `delay`=7, 20 samples → `ram_wr_addr` wraps 7→0; `dout` = sample n−7 once unmuted; no gaps.
- Delay change: in RUN at `delay`=4, switch to 2 with `in_valid` in the same cycle → that sample and the next output 0; the third outputs the sample 2 accepts earlier.
- Enable/zero: `en` low for 5 cycles with `in_valid` toggling → no RAM access, `wr_ptr` held; `en` high again → refill mute of `delay_q` samples; `delay`=0 behaves as 1.
- Sparse input: `in_valid` every 3rd cycle, `delay`=2 → outputs track accepts only, latency still 3 edges.
